// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encodings, default datapath width and small op-decode helpers.
// Optional feature macro used by the top: MDU_FAST_MUL_EN.
package mul_div_unit_pkg;

    localparam int MDU_WIDTH = 32;

    // Op codes as presented on the op port by the control unit.
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_t;

    // Upper op bit selects divide, low bit selects unsigned.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit the quotient bit.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] partial;

    // Trial subtract; the remainder is always below the divisor so the
    // restored or reduced value fits back into WIDTH bits.
    always_comb begin
        partial = {rem_in, bit_in};
        q_bit   = (partial >= {1'b0, divisor});
        rem_out = q_bit ? WIDTH'(partial - {1'b0, divisor}) : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, one bit per
// CALC cycle, on operand magnitudes; FIX applies the result signs.
// Define MDU_FAST_MUL_EN to compute products in a single cycle instead.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q;
    logic               div_q;      // operation in flight is a divide
    logic               neg_res_q;  // negate product / quotient in FIX
    logic               neg_rem_q;  // negate remainder in FIX
    logic               div0_q;     // divide by zero: acc already holds result
    logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;      // {upper, lower}: product or {rem, quotient}

    // Operand decode for the request presented this cycle.
    logic               sign_a, sign_b, div_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;

    always_comb begin
        sign_a   = op_is_signed(op) & A[WIDTH-1];
        sign_b   = op_is_signed(op) & B[WIDTH-1];
        mag_a    = sign_a ? (WIDTH'(0) - A) : A;
        mag_b    = sign_b ? (WIDTH'(0) - B) : B;
        div_zero = op_is_div(op) && (B == '0);
    end

    // One shift-add multiply step: add multiplicand into the upper half
    // when the current multiplier bit is set, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    logic [WIDTH-1:0]   div_rem;
    logic               div_qbit;
    logic [2*WIDTH-1:0] div_next;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
        .bit_in  (acc_q[WIDTH-1]),
        .divisor (opb_q),
        .rem_out (div_rem),
        .q_bit   (div_qbit)
    );

    always_comb div_next = {div_rem, acc_q[WIDTH-2:0], div_qbit};

    // Sign correction applied on the way into HI/LO.
    logic [2*WIDTH-1:0] fixed;
    logic [WIDTH-1:0]   rem_raw, quo_raw;

    always_comb begin
        rem_raw = acc_q[2*WIDTH-1:WIDTH];
        quo_raw = acc_q[WIDTH-1:0];
        if (div0_q) begin
            fixed = acc_q;
        end else if (div_q) begin
            fixed = {(neg_rem_q ? (WIDTH'(0) - rem_raw) : rem_raw),
                     (neg_res_q ? (WIDTH'(0) - quo_raw) : quo_raw)};
        end else begin
            fixed = neg_res_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (div_zero) begin
                        state_d = ST_FIX;
`ifdef MDU_FAST_MUL_EN
                    end else if (!op_is_div(op)) begin
                        state_d = ST_FIX;
`endif
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: operand latch, iterations, result commit and MTHI/MTLO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            opb_q     <= '0;
            acc_q     <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q     <= CNT_W'(WIDTH);
                        div_q     <= op_is_div(op);
                        neg_res_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        div0_q    <= div_zero;
                        opb_q     <= mag_b;
                        if (div_zero) begin
                            acc_q <= {A, {WIDTH{1'b1}}};
`ifdef MDU_FAST_MUL_EN
                        end else if (!op_is_div(op)) begin
                            acc_q <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif
                        end else begin
                            acc_q <= {{WIDTH{1'b0}}, mag_a};
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                ST_CALC: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    acc_q <= div_q ? div_next : mul_next;
                end
                ST_FIX: begin
                    hi <= fixed[2*WIDTH-1:WIDTH];
                    lo <= fixed[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule
